// File: rtl/bp_update_scheduler_pkg.sv
// bp_update_scheduler_pkg: shared types for the branch-predictor update scheduler
`ifndef XLEN
`define XLEN 32
`endif
package bp_update_scheduler_pkg;
  localparam int BP_RES_WIDTH = 3;
  typedef struct packed {
    logic [`XLEN-1:0] pc;
    logic             direction;
    logic [`XLEN-1:0] target;
  } BP_UPD_PACKET;
  typedef enum logic [1:0] {BPU_RUN, BPU_DRAIN, BPU_HALTED} BPU_STATE;
endpackage

// File: rtl/bp_update_scheduler_compact.sv
// bp_upd_compact: packs valid resolution slots (2 oldest) into queue offsets and limits them to free space
`ifndef XLEN
`define XLEN 32
`endif
module bp_upd_compact
  import bp_update_scheduler_pkg::*;
#(
  parameter int PTR_W = 3
) (
  input  logic [BP_RES_WIDTH-1:0]      en_i,
  input  logic                         accept_en_i,
  input  logic [PTR_W:0]               free_i,
  output logic [BP_RES_WIDTH-1:0][1:0] offset_o,
  output logic [BP_RES_WIDTH-1:0]      accept_o,
  output logic [1:0]                   acc_cnt_o,
  output logic                         drop_o
);
  always_comb begin
    offset_o[2] = 2'd0;
    offset_o[1] = {1'b0, en_i[2]};
    offset_o[0] = {1'b0, en_i[2]} + {1'b0, en_i[1]};
    for (int i = 0; i < BP_RES_WIDTH; i++)
      accept_o[i] = accept_en_i && en_i[i] && ((PTR_W+1)'(offset_o[i]) < free_i);
    acc_cnt_o = {1'b0, accept_o[2]} + {1'b0, accept_o[1]} + {1'b0, accept_o[0]};
    drop_o = accept_en_i && |(en_i & ~accept_o);
  end
endmodule

// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: queues resolved branches in program order and drains one per cycle to the predictor
`ifndef XLEN
`define XLEN 32
`endif
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              res_EN,
  input  logic [2:0][`XLEN-1:0]   res_pc,
  input  logic [2:0]              res_direction,
  input  logic [2:0][`XLEN-1:0]   res_target,
  input  logic                    update_hold,
  input  logic                    flush,
  input  logic                    halt_req,
  output logic                    update_EN,
  output logic [`XLEN-1:0]        update_pc,
  output logic                    update_direction,
  output logic [`XLEN-1:0]        update_target,
  output logic [PTR_W:0]          free_cnt,
  output logic                    res_stall,
  output logic                    overflow,
  output logic                    halt_ack
);
  BPU_STATE                       state_q, state_d;
  logic [PTR_W-1:0]               head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]                 count_q, count_d;
  logic                           en_q, en_d, overflow_q, overflow_d;
  BP_UPD_PACKET                   mem_q [DEPTH];
  BP_UPD_PACKET                   in_pkt [BP_RES_WIDTH];
  BP_UPD_PACKET                   out_q, out_d, head_pkt;
  logic [BP_RES_WIDTH-1:0][1:0]   offset;
  logic [BP_RES_WIDTH-1:0]        accept;
  logic [1:0]                     acc_cnt;
  logic                           drop, accept_en, deq;

  assign accept_en = (state_q == BPU_RUN) && !flush;

  bp_upd_compact #(.PTR_W(PTR_W)) u_compact (
    .en_i        (res_EN),
    .accept_en_i (accept_en),
    .free_i      (free_cnt),
    .offset_o    (offset),
    .accept_o    (accept),
    .acc_cnt_o   (acc_cnt),
    .drop_o      (drop)
  );

  // An empty queue forwards the oldest accepted slot straight into the output register.
  always_comb begin
    for (int i = 0; i < BP_RES_WIDTH; i++)
      in_pkt[i] = '{pc: res_pc[i], direction: res_direction[i], target: res_target[i]};
    head_pkt = (count_q != '0) ? mem_q[head_q] : in_pkt[res_EN[2] ? 2 : res_EN[1] ? 1 : 0];
    deq = (count_q != '0 || acc_cnt != 2'd0) && !update_hold && !flush && (state_q != BPU_HALTED);
    head_d = flush ? '0 : head_q + PTR_W'(deq);
    tail_d = flush ? '0 : tail_q + PTR_W'(acc_cnt);
    count_d = flush ? '0 : count_q + (PTR_W+1)'(acc_cnt) - (PTR_W+1)'(deq);
    en_d = (update_hold && !flush) ? en_q : deq;
    out_d = deq ? head_pkt : out_q;
    overflow_d = overflow_q | drop;
    state_d = (state_q == BPU_RUN) ? (halt_req ? BPU_DRAIN : BPU_RUN) :
              !halt_req ? BPU_RUN :
              (state_q == BPU_HALTED || flush || (count_q == '0 && !en_q)) ? BPU_HALTED : BPU_DRAIN;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= BPU_RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      en_q       <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      en_q       <= en_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < BP_RES_WIDTH; i++)
      if (accept[i]) mem_q[tail_q + PTR_W'(offset[i])] <= in_pkt[i];
  end

  assign update_EN        = en_q;
  assign update_pc        = out_q.pc;
  assign update_direction = out_q.direction;
  assign update_target    = out_q.target;
  assign free_cnt         = (PTR_W+1)'(DEPTH) - count_q;
  assign res_stall        = free_cnt < (PTR_W+1)'(BP_RES_WIDTH);
  assign overflow         = overflow_q;
  assign halt_ack         = (state_q == BPU_HALTED);
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: directed stimulus with a queue scoreboard checked by an independent output monitor
`ifndef XLEN
`define XLEN 32
`endif
module tb_bp_update_scheduler;
  import bp_update_scheduler_pkg::*;
  logic                  clock = 1'b0, reset = 1'b1;
  logic [2:0]            res_EN = '0, res_direction = '0;
  logic [2:0][`XLEN-1:0] res_pc = '0, res_target = '0;
  logic                  update_hold = 1'b0, flush = 1'b0, halt_req = 1'b0;
  logic                  update_EN, update_direction, res_stall, overflow, halt_ack;
  logic [`XLEN-1:0]      update_pc, update_target;
  logic [3:0]            free_cnt;
  BP_UPD_PACKET          exp_q [$];
  BP_UPD_PACKET          mon_e;
  logic                  held;
  int                    errors = 0, checks = 0;

  bp_update_scheduler #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .res_EN(res_EN), .res_pc(res_pc),
    .res_direction(res_direction), .res_target(res_target),
    .update_hold(update_hold), .flush(flush), .halt_req(halt_req),
    .update_EN(update_EN), .update_pc(update_pc), .update_direction(update_direction),
    .update_target(update_target), .free_cnt(free_cnt), .res_stall(res_stall),
    .overflow(overflow), .halt_ack(halt_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // A held edge re-presents the previous update, so only fresh loads are popped.
  always @(posedge clock or posedge reset)
    if (reset) held <= 1'b0;
    else held <= update_hold;

  always @(negedge clock)
    if (!reset && update_EN && !held) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got pc %0h expected no update", update_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("upd_pc", update_pc, mon_e.pc);
        chk("upd_dir", update_direction, mon_e.direction);
        chk("upd_target", update_target, mon_e.target);
      end
    end

  task automatic enq(input logic [2:0] en, input logic [31:0] base, input logic [2:0] dir, input int npush);
    int k = 0;
    for (int s = 2; s >= 0; s--) begin
      res_pc[s]        = base + 32'(4 * (2 - s));
      res_target[s]    = res_pc[s] << 1;
      res_direction[s] = dir[s];
      if (en[s] && k < npush) begin
        exp_q.push_back('{pc: res_pc[s], direction: dir[s], target: res_target[s]});
        k++;
      end
    end
    res_EN = en;
    cyc();
    res_EN = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(free_cnt == 4'd8 && !update_EN) && n < 60) begin
      cyc();
      n++;
    end
    chk(name, 64'(n < 60), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    chk("rst_en", update_EN, 0);
    chk("rst_pc", update_pc, 0);
    chk("rst_free", free_cnt, 8);
    chk("rst_stall", res_stall, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ack", halt_ack, 0);
    reset = 1'b0;
    cyc();
    // single branch
    enq(3'b100, 32'h40, 3'b100, 1);
    chk("single_en", update_EN, 1);
    cyc();
    chk("single_en_fall", update_EN, 0);
    chk("single_free", free_cnt, 8);
    // ordering and pointer wrap
    enq(3'b111, 32'h100, 3'b101, 3); chk("wrap_free1", free_cnt, 6);
    cyc();                            chk("wrap_free2", free_cnt, 7);
    enq(3'b111, 32'h10c, 3'b010, 3); chk("wrap_free3", free_cnt, 5);
    cyc();                            chk("wrap_free4", free_cnt, 6);
    enq(3'b111, 32'h118, 3'b110, 3); chk("wrap_free5", free_cnt, 4);
    cyc();                            chk("wrap_free6", free_cnt, 5);
    enq(3'b111, 32'h124, 3'b011, 3); chk("wrap_free7", free_cnt, 3);
    chk("wrap_stall", res_stall, 0);
    wait_drain("wrap_drain");
    // hold freezes the output
    enq(3'b111, 32'h200, 3'b111, 3);
    chk("hold_en0", update_EN, 1);
    update_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_en", update_EN, 1);
      chk("hold_pc", update_pc, 32'h200);
      chk("hold_free", free_cnt, 6);
    end
    update_hold = 1'b0;
    wait_drain("hold_drain");
    // drain then halt
    update_hold = 1'b1;
    enq(3'b111, 32'h240, 3'b000, 3);
    chk("halt_free0", free_cnt, 5);
    update_hold = 1'b0;
    halt_req = 1'b1;
    cyc();
    enq(3'b111, 32'h280, 3'b111, 0);
    chk("drain_ignore_free", free_cnt, 7);
    chk("drain_ignore_ovf", overflow, 0);
    begin
      int n = 0;
      while (update_EN && n < 10) begin
        cyc();
        n++;
      end
      chk("halt_en_fell", 64'(n < 10), 64'd1);
    end
    chk("halt_ack_early", halt_ack, 0);
    cyc();
    chk("halt_ack", halt_ack, 1);
    chk("halt_free", free_cnt, 8);
    halt_req = 1'b0;
    cyc();
    chk("halt_release", halt_ack, 0);
    // overflow
    update_hold = 1'b1;
    enq(3'b111, 32'h300, 3'b111, 3);
    enq(3'b111, 32'h30c, 3'b000, 3);
    chk("ovf_free6", free_cnt, 2);
    chk("ovf_stall6", res_stall, 1);
    enq(3'b111, 32'h318, 3'b101, 2);
    chk("ovf_free", free_cnt, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_stall", res_stall, 1);
    update_hold = 1'b0;
    wait_drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    // flush with simultaneous enqueue under hold
    enq(3'b111, 32'h400, 3'b010, 1);
    update_hold = 1'b1;
    enq(3'b111, 32'h40c, 3'b111, 0);
    chk("flush_pre_free", free_cnt, 3);
    chk("flush_pre_en", update_EN, 1);
    flush = 1'b1;
    enq(3'b011, 32'h418, 3'b000, 0);
    flush = 1'b0;
    chk("flush_free", free_cnt, 8);
    chk("flush_en", update_EN, 0);
    chk("flush_ovf", overflow, 1);
    update_hold = 1'b0;
    repeat (3) cyc();
    chk("flush_quiet", update_EN, 0);
    // async reset in DRAIN
    update_hold = 1'b1;
    enq(3'b111, 32'h500, 3'b000, 0);
    halt_req = 1'b1;
    cyc();
    chk("mid_drain_free", free_cnt, 5);
    #2 reset = 1'b1;
    #1;
    chk("areset_en", update_EN, 0);
    chk("areset_free", free_cnt, 8);
    chk("areset_ovf", overflow, 0);
    chk("areset_ack", halt_ack, 0);
    chk("areset_pc", update_pc, 0);
    halt_req = 1'b0;
    update_hold = 1'b0;
    cyc();
    reset = 1'b0;
    repeat (2) cyc();
    chk("post_reset_en", update_EN, 0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
